rll_key_loader: RTL and testbench

RLL_KEY_LOADER -- requirements
Module: rll_key_loader

---
 rtl/rll_pkg.sv | 24 ++
 rtl/rll_key_shreg.sv | 58 +++++
 rtl/rll_key_loader.sv | 141 ++++++++++++++
 tb/tb_rll_key_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_pkg.sv
// Shared definitions for the RLL key loader.
//   - state_e       : loader FSM states (PARITY exists only when
//                     KEY_PARITY_CHECK_EN is defined)
//   - KEY_W_DEFAULT : default key width
//   - cnt_width()   : bit counter width, ceil(log2(w+1))
package rll_pkg;

    localparam int unsigned KEY_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef KEY_PARITY_CHECK_EN
        ST_PARITY,
`endif
        ST_COMMIT
    } state_e;

    // Wide enough to hold the value w itself, so the counter never wraps.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// Shadow shift register and bit counter for the RLL key loader.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear shadow and counter (has priority over shift_i)
//   shift_i      : accept bit_i this cycle
//   bit_i        : serial key bit, LSB first
//   shadow_o     : partially/fully loaded key
//   last_o       : the next accepted bit is the KEY_W-th one
module rll_key_shreg
    import rll_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [KEY_W-1:0] shadow_o,
    output logic             last_o
);

    localparam int unsigned CNT_W = cnt_width(KEY_W);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;

    // The counter doubles as the write index: accepted bit n lands in shadow bit n.
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (clr_i) begin
            shadow_d = '0;
            count_d  = '0;
        end else if (shift_i && (count_q < CNT_W'(KEY_W))) begin
            for (int unsigned i = 0; i < KEY_W; i++) begin
                if (count_q == CNT_W'(i)) begin
                    shadow_d[i] = bit_i;
                end
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    assign shadow_o = shadow_q;
    assign last_o   = (count_q == CNT_W'(KEY_W - 1));

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader for an RLL-locked netlist: shifts KEY_W bits in LSB
// first and commits them atomically to key_q (bit i drives keyIn_0_i).
// Optional feature macro: KEY_PARITY_CHECK_EN -- adds a trailing even-parity
// bit; a mismatch rejects the load with a one-cycle key_err pulse.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start                : begin (or restart) a load
//   clear                : zero the committed key, abort any load
//   ser_data, ser_valid  : serial bit and its qualifier
//   ser_ready            : a bit is accepted when ser_valid && ser_ready
//   key_q, key_valid     : committed key and its valid flag
//   busy                 : load in progress (SHIFT/PARITY/COMMIT)
//   key_err              : rejected-load pulse (0 without parity check)
module rll_key_loader
    import rll_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             ser_data,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_q,
    output logic             key_valid,
    output logic             busy,
    output logic             key_err
);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic             sh_clr;
    logic             sh_shift;
    logic             sh_last;
    logic [KEY_W-1:0] shadow;

`ifdef KEY_PARITY_CHECK_EN
    logic err_q, err_d;
    assign ser_ready = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign key_err   = err_q;
`else
    assign ser_ready = (state_q == ST_SHIFT);
    assign key_err   = 1'b0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign key_valid = valid_q;
    assign accept    = ser_valid && ser_ready;

    // A start outside COMMIT (fresh load or restart) and any clear wipe the
    // shadow/counter; the shreg gives clear priority over a same-cycle shift.
    assign sh_clr   = clear || (start && (state_q != ST_COMMIT));
    assign sh_shift = accept && (state_q == ST_SHIFT);

    rll_key_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (sh_clr),
        .shift_i  (sh_shift),
        .bit_i    (ser_data),
        .shadow_o (shadow),
        .last_o   (sh_last)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        valid_d = valid_q;
`ifdef KEY_PARITY_CHECK_EN
        err_d   = 1'b0;
`endif
        if (clear) begin
            state_d = ST_IDLE;
            key_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (start) begin
                        state_d = ST_SHIFT;
                    end else if (accept && sh_last) begin
`ifdef KEY_PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
`ifdef KEY_PARITY_CHECK_EN
                ST_PARITY: begin
                    if (start) begin
                        state_d = ST_SHIFT;
                    end else if (accept) begin
                        // Even parity: the extra bit makes the total count of ones even.
                        if (ser_data == (^shadow)) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    key_d   = shadow;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            valid_q <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= valid_d;
`ifdef KEY_PARITY_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic [15:0] key_q;
    logic        key_valid;
    logic        busy;
    logic        key_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [15:0] exp_key   = '0;
    logic        exp_valid = 1'b0;

    rll_key_loader #(.KEY_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .key_q     (key_q),
        .key_valid (key_valid),
        .busy      (busy),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Full load of k; optional ser_valid toggling, parity choice, start during COMMIT.
    task automatic load_key(input logic [15:0] k, input bit toggle, input bit par_good,
                            input bit start_in_commit);
        logic [15:0] prev_key;
        logic        prev_valid;
        bit          commit_exp;
        int unsigned i;
        int unsigned cyc;
        prev_key   = exp_key;
        prev_valid = exp_valid;
        commit_exp = 1'b1;
        i          = 0;
        cyc        = 0;
        start = 1'b1;
        step;
        start = 1'b0;
        n_cmp++;
        if (ser_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_enter_shift: ready=%b busy=%b required 1/1", ser_ready, busy);
        end
        while (i < 16 && cyc < 64) begin
            ser_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            ser_data  = ser_valid ? k[i] : ~k[i];
            step;
            n_cmp++;
            if (key_q !== prev_key) begin
                n_err++;
                $display("FAIL load_hold: key_q=%h required %h (bit %0d)", key_q, prev_key, i);
            end
            if (ser_valid) i++;
            cyc++;
        end
`ifdef KEY_PARITY_CHECK_EN
        ser_valid  = 1'b1;
        ser_data   = par_good ? (^k) : ~(^k);
        commit_exp = par_good;
        step;
        n_cmp++;
        if (key_err !== !par_good || key_q !== prev_key) begin
            n_err++;
            $display("FAIL parity_result: key_err=%b key_q=%h required %b %h",
                     key_err, key_q, !par_good, prev_key);
        end
`endif
        // Offered while not ready: must be ignored.
        ser_valid = 1'b1;
        ser_data  = par_good;
        if (commit_exp) begin
            n_cmp++;
            if (busy !== 1'b1 || ser_ready !== 1'b0 || key_valid !== prev_valid) begin
                n_err++;
                $display("FAIL commit_state: busy=%b ready=%b valid=%b required 1 0 %b",
                         busy, ser_ready, key_valid, prev_valid);
            end
        end
        start = start_in_commit;
        step;
        start     = 1'b0;
        ser_valid = 1'b0;
        if (commit_exp) begin
            exp_key   = k;
            exp_valid = 1'b1;
        end
        n_cmp++;
        if (key_q !== exp_key || key_valid !== exp_valid) begin
            n_err++;
            $display("FAIL commit_key: key_q=%h valid=%b required %h %b",
                     key_q, key_valid, exp_key, exp_valid);
        end
        n_cmp++;
        if (busy !== 1'b0 || key_err !== 1'b0 || ser_ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_commit_idle: busy=%b err=%b ready=%b required 0 0 0",
                     busy, key_err, ser_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0 || busy !== 1'b0 ||
            ser_ready !== 1'b0 || key_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: key=%h valid=%b busy=%b ready=%b err=%b required all 0",
                     key_q, key_valid, busy, ser_ready, key_err);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic_load;
        load_key(16'hA5C3, 1'b0, 1'b1, 1'b0);
        step;
        n_cmp++;
        if (busy !== 1'b0 || key_q !== 16'hA5C3) begin
            n_err++;
            $display("FAIL basic_idle_after: busy=%b key=%h required 0 a5c3", busy, key_q);
        end
    endtask

    task automatic test_toggle_valid;
        clear = 1'b1;
        step;
        clear     = 1'b0;
        exp_key   = 16'h0000;
        exp_valid = 1'b0;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear_idle: key=%h valid=%b required 0000 0", key_q, key_valid);
        end
        load_key(16'hA5C3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_restart;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            ser_valid = 1'b1;
            ser_data  = 1'b1;
            step;
        end
        ser_valid = 1'b0;
        load_key(16'h1234, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_start_in_commit;
        load_key(16'h5A0F, 1'b0, 1'b1, 1'b1);
        step;
        n_cmp++;
        if (busy !== 1'b0 || ser_ready !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_commit_ignored: busy=%b ready=%b required 0 0", busy, ser_ready);
        end
    endtask

    task automatic test_clear_priority;
        logic [15:0] ones;
        ones  = 16'hFFFF;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            ser_valid = 1'b1;
            ser_data  = ones[j];
            step;
        end
`ifdef KEY_PARITY_CHECK_EN
        ser_data = 1'b0;
        step;
`endif
        ser_valid = 1'b0;
        clear = 1'b1;
        start = 1'b1;
        step;
        clear = 1'b0;
        start = 1'b0;
        exp_key   = 16'h0000;
        exp_valid = 1'b0;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_over_commit: key=%h valid=%b busy=%b required 0000 0 0",
                     key_q, key_valid, busy);
        end
    endtask

    task automatic test_clear_start;
        load_key(16'h1234, 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        start = 1'b1;
        step;
        clear = 1'b0;
        start = 1'b0;
        exp_key   = 16'h0000;
        exp_valid = 1'b0;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0 || busy !== 1'b0 || ser_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_with_start: key=%h valid=%b busy=%b ready=%b required 0000 0 0 0",
                     key_q, key_valid, busy, ser_ready);
        end
        start = 1'b1;
        step;
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            ser_valid = 1'b1;
            ser_data  = 1'b1;
            step;
        end
        ser_valid = 1'b0;
        clear = 1'b1;
        step;
        clear = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ser_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_mid_load: busy=%b ready=%b required 0 0", busy, ser_ready);
        end
    endtask

    task automatic test_reset_midload;
        load_key(16'h1234, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        step;
        start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            ser_valid = 1'b1;
            ser_data  = 1'b1;
            step;
        end
        #2;
        rst = 1'b1;
        #1;
        exp_key   = 16'h0000;
        exp_valid = 1'b0;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0 || busy !== 1'b0 ||
            ser_ready !== 1'b0 || key_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: key=%h valid=%b busy=%b ready=%b err=%b required all 0",
                     key_q, key_valid, busy, ser_ready, key_err);
        end
        step;
        rst = 1'b0;
        repeat (20) step;
        ser_valid = 1'b0;
        n_cmp++;
        if (key_q !== 16'h0000 || key_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_commit: key=%h valid=%b busy=%b required 0000 0 0",
                     key_q, key_valid, busy);
        end
    endtask

`ifdef KEY_PARITY_CHECK_EN
    task automatic test_parity;
        load_key(16'h1234, 1'b0, 1'b1, 1'b0);
        load_key(16'h0001, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (key_q !== 16'h1234 || key_valid !== 1'b1) begin
            n_err++;
            $display("FAIL parity_reject_keeps: key=%h valid=%b required 1234 1", key_q, key_valid);
        end
        load_key(16'h0001, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        clear     = 1'b0;
        ser_data  = 1'b0;
        ser_valid = 1'b0;
        test_reset;
        test_basic_load;
        test_toggle_valid;
        test_restart;
        test_start_in_commit;
        test_clear_priority;
        test_clear_start;
        test_reset_midload;
`ifdef KEY_PARITY_CHECK_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
